// File: rtl/mult_scheduler.sv
// Time-shared Q1.15 multiplier: one signed multiplier serves NCH channels per lrclk frame,
// with per-channel enable, saturating writeback and an atomic output update.
module mult_scheduler #(
  parameter int BITSIZE = 16,
  parameter int NCH     = 4
) (
  input  logic                   bclk,
  input  logic                   reset_n,
  input  logic                   lrclk,
  input  logic [NCH-1:0]         ch_en,
  input  logic [NCH*BITSIZE-1:0] in_a,
  input  logic [NCH*BITSIZE-1:0] in_b,
  output logic [NCH*BITSIZE-1:0] out,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   overrun
);

  generate
    if (BITSIZE != 16) begin : g_bad_bitsize
      $error("mult_scheduler: BITSIZE must be 16");
    end
    if (NCH < 1 || NCH > 32) begin : g_bad_nch
      $error("mult_scheduler: NCH must be in 1..32");
    end
  endgenerate

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW = BITSIZE + 1;
  localparam logic [IW-1:0]      LAST_IDX = IW'(NCH - 1);
  localparam logic [BITSIZE-1:0] SAT_MAX  = {1'b0, {(BITSIZE-1){1'b1}}};
  localparam logic [BITSIZE-1:0] SAT_MIN  = {1'b1, {(BITSIZE-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic sync1, sync2, sync3;
  logic frame_start;

  logic [NCH*BITSIZE-1:0] cap_a, cap_b;
  logic [NCH-1:0]         cap_en;
  logic [IW-1:0]          idx;
  logic [BITSIZE-1:0]     mul_a, mul_b;
  logic [PW-1:0]          prod;
  logic [IW-1:0]          wb_idx;
  logic                   wb_pend;
  logic [BITSIZE-1:0]     wb_data;
  logic [BITSIZE-1:0]     rbuf [NCH];

  // lrclk is data only: two-flop synchronizer plus an edge-detect delay flop
  always_ff @(posedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= lrclk;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign frame_start = sync2 & ~sync3;

  always_ff @(posedge bclk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = RUN;
      RUN:     if (idx == LAST_IDX) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Disabled channels feed zero operands, so their slot still runs and yields 0
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (cap_en[idx]) begin
      mul_a = cap_a[idx*BITSIZE +: BITSIZE];
      mul_b = cap_b[idx*BITSIZE +: BITSIZE];
    end
  end

  // prod holds product bits [2*BITSIZE-1 : BITSIZE-1]; the lower bits never reach the result
  always_comb begin
    wb_data = prod[BITSIZE-1:0];
    if (prod[BITSIZE] != prod[BITSIZE-1]) wb_data = prod[BITSIZE] ? SAT_MIN : SAT_MAX;
  end

  always_ff @(posedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      cap_a     <= '0;
      cap_b     <= '0;
      cap_en    <= '0;
      idx       <= '0;
      prod      <= '0;
      wb_idx    <= '0;
      wb_pend   <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int unsigned k = 0; k < NCH; k++) rbuf[k] <= '0;
    end else begin
      out_valid <= 1'b0;
      wb_pend   <= 1'b0;

      case (state)
        IDLE: begin
          if (frame_start) begin
            cap_a  <= in_a;
            cap_b  <= in_b;
            cap_en <= ch_en;
            idx    <= '0;
          end
        end
        RUN: begin
          prod    <= PW'(({{BITSIZE{mul_a[BITSIZE-1]}}, mul_a} *
                          {{BITSIZE{mul_b[BITSIZE-1]}}, mul_b}) >> (BITSIZE - 1));
          wb_idx  <= idx;
          wb_pend <= 1'b1;
          idx     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
        DONE: begin
          for (int unsigned k = 0; k < NCH; k++) out[k*BITSIZE +: BITSIZE] <= rbuf[k];
          out_valid <= 1'b1;
        end
        default: ;
      endcase

      if (wb_pend) rbuf[wb_idx] <= wb_data;

      if (frame_start && state != IDLE) overrun <= 1'b1;
    end
  end

endmodule

// File: doc/mult_scheduler.md
MULT_SCHEDULER -- requirements
Module: mult_scheduler

Interface
REQ-001 Parameter BITSIZE, default 16, sample width in bits; any value other than 16 SHALL raise an elaboration error.
REQ-002 Parameter NCH, default 4, number of multiply channels; values outside 1..32 SHALL raise an elaboration error.
REQ-003 bclk  input  1  sole clock; 64 bclk periods per lrclk period.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 lrclk  input  1  frame clock, asynchronous to bclk; treated as data and never used as a clock.
REQ-006 ch_en  input  NCH  per-channel enable, sampled at operand capture.
REQ-007 in_a  input  NCH*BITSIZE  signed Q1.15 operand A per channel; channel k occupies bits [k*BITSIZE +: BITSIZE].
REQ-008 in_b  input  NCH*BITSIZE  signed Q1.15 operand B per channel, same packing as in_a.
REQ-009 out  output  NCH*BITSIZE  signed Q1.15 products, same packing as in_a; registered.
REQ-010 out_valid  output  1  one-bclk pulse indicating that out has been updated.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 overrun  output  1  sticky flag set when a frame start arrives while busy.

Function
REQ-013 lrclk SHALL pass through a 2-flop synchronizer, then a third delay flop; frame start = sync2 & ~sync3.
REQ-014 Exactly one signed BITSIZE x BITSIZE multiplier SHALL exist; it is time-shared across all channels.
REQ-015 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-016 IDLE: on frame start, in_a, in_b and ch_en SHALL be captured into internal registers at the same edge; index is set to 0 and the FSM moves to RUN.
REQ-017 RUN: each edge SHALL register the full 2*BITSIZE product of the captured operands for the current index, then increment index; after index NCH-1 the FSM moves to DRAIN.
REQ-018 Writeback: the product registered at one edge SHALL be scaled and written to internal result buffer slot k at the next edge.
REQ-019 DRAIN: one edge SHALL write back the last product; the FSM then moves to DONE.
REQ-020 DONE: one edge SHALL copy the whole buffer to out atomically, set out_valid high for exactly that cycle, and return to IDLE.
REQ-021 Latency: with e0 the first bclk edge that samples lrclk high, out and out_valid SHALL update at edge e(NCH+4); for NCH=4 this is e8. Total latency is at most 36 edges, well within a 64-edge frame.
REQ-022 Scaling: result = product[2*BITSIZE-2 : BITSIZE-1], i.e. an arithmetic shift right by 15 with truncation.
REQ-023 Saturation: if product[2*BITSIZE-1] differs from product[2*BITSIZE-2], result SHALL be 0x7FFF for a positive product and 0x8000 for a negative one; the only overflow case is 0x8000*0x8000, which yields 0x7FFF.
REQ-024 A channel with captured ch_en=0 SHALL still occupy its RUN slot (fixed timing) and SHALL write result 0.
REQ-025 Inputs changing after capture SHALL NOT affect the current frame's results.
REQ-026 A frame start while busy SHALL be ignored (no restart, no recapture) and SHALL set overrun; overrun clears only on reset.
REQ-027 out SHALL hold its value between DONE events; out_valid is 0 in all other cycles.
REQ-028 A frame start coinciding with the DONE edge counts as busy (overrun) because the state is not IDLE at that edge.

Reset
REQ-029 reset_n low SHALL asynchronously force: state IDLE, index 0, synchronizer flops 0, buffer 0, out 0, out_valid 0, busy 0, overrun 0.
REQ-030 Reset asserted mid-RUN SHALL abort the frame; out SHALL read 0 with no out_valid pulse.
REQ-031 After release, the first frame start SHALL require a fresh 0->1 transition of lrclk seen through the synchronizer.

Verification
REQ-032 NCH=4; ch0 0x4000*0x4000, ch1 0x8000*0x4000, ch2 0x7FFF*0x7FFF, ch3 0x0000*0x1234; one lrclk rise -> out = {0x2000, 0xC000, 0x7FFE, 0x0000}, with the out_valid pulse at e8 only.
REQ-033 ch0 0x8000*0x8000 -> out ch0 = 0x7FFF (saturated).
REQ-034 ch_en = 4'b0101 with nonzero operands on all channels -> ch1 = ch3 = 0; out_valid timing unchanged (e8).
REQ-035 A second lrclk rise forced while busy -> overrun = 1, no extra out_valid pulse, out equals the first frame's results; overrun stays 1 across later frames.
REQ-036 reset_n pulsed low at e4 -> out = 0, out_valid never pulses, busy = 0 immediately; the next lrclk rise completes normally with correct results.
REQ-037 in_a and in_b changed on every bclk edge after capture -> out reflects only the operands captured at e2.
